// File: rtl/hpi_access_arbiter_if.sv
// Request/response and HPI strobe bundle between requesters, the arbiter and hpi_io_intf.
interface hpi_access_arbiter_if;
    logic        req0;
    logic        req1;
    logic        we0;
    logic        we1;
    logic [15:0] addr0;
    logic [15:0] addr1;
    logic [15:0] wdata0;
    logic [15:0] wdata1;
    logic        ack0;
    logic        ack1;
    logic [15:0] rdata;
    logic        busy;
    logic [1:0]  from_sw_address;
    logic [15:0] from_sw_data_out;
    logic [15:0] from_sw_data_in;
    logic        from_sw_r;
    logic        from_sw_w;
    logic        from_sw_cs;

    // Requesters plus the HPI side that returns read data.
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, from_sw_data_in,
        input  ack0, ack1, rdata, busy, from_sw_address, from_sw_data_out,
        input  from_sw_r, from_sw_w, from_sw_cs
    );

    // The arbiter/sequencer itself.
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, from_sw_data_in,
        output ack0, ack1, rdata, busy, from_sw_address, from_sw_data_out,
        output from_sw_r, from_sw_w, from_sw_cs
    );
endinterface

// File: rtl/hpi_access_arbiter.sv
// Two-port round-robin arbiter that expands each word access into the HPI
// ADDRESS-port write followed by a DATA-port read or write.
module hpi_access_arbiter #(
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned REC_CYC    = 2
) (
    input logic               Clk,
    input logic               Reset,
    hpi_access_arbiter_if.slave bus
);

    localparam int unsigned MaxCyc = (STROBE_CYC > REC_CYC) ? STROBE_CYC : REC_CYC;
    localparam int unsigned CntW   = $clog2(MaxCyc) + 1;
    localparam logic [CntW-1:0] StbLoad = CntW'(STROBE_CYC - 1);
    localparam logic [CntW-1:0] RecLoad = CntW'(REC_CYC - 1);

    typedef enum logic [3:0] {
        StIdle, StASetup, StAStb, StAHold, StARec,
        StDSetup, StDStb, StDHold, StDRec, StDone
    } state_e;

    state_e          state;
    logic [CntW-1:0] cnt;
    logic            gnt;         // port currently being served
    logic            last_grant;  // port served most recently
    logic            we_q;
    logic [15:0]     wdata_q;

    // Sequencer: every output is registered and set on entry to the state that owns it.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state                <= StIdle;
            cnt                  <= '0;
            gnt                  <= 1'b0;
            last_grant           <= 1'b1;
            we_q                 <= 1'b0;
            wdata_q              <= '0;
            bus.ack0             <= 1'b0;
            bus.ack1             <= 1'b0;
            bus.rdata            <= '0;
            bus.busy             <= 1'b0;
            bus.from_sw_address  <= 2'b00;
            bus.from_sw_data_out <= '0;
            bus.from_sw_r        <= 1'b1;
            bus.from_sw_w        <= 1'b1;
            bus.from_sw_cs       <= 1'b1;
        end else begin
            bus.ack0 <= 1'b0;
            bus.ack1 <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (bus.req0 || bus.req1) begin
                        // Port 0 wins unless port 1 also asks and port 0 went last.
                        if (bus.req0 && (!bus.req1 || last_grant)) begin
                            gnt                  <= 1'b0;
                            last_grant           <= 1'b0;
                            we_q                 <= bus.we0;
                            wdata_q              <= bus.wdata0;
                            bus.from_sw_data_out <= bus.addr0;
                        end else begin
                            gnt                  <= 1'b1;
                            last_grant           <= 1'b1;
                            we_q                 <= bus.we1;
                            wdata_q              <= bus.wdata1;
                            bus.from_sw_data_out <= bus.addr1;
                        end
                        state               <= StASetup;
                        bus.busy            <= 1'b1;
                        bus.from_sw_cs      <= 1'b0;
                        bus.from_sw_address <= 2'b10;
                        bus.from_sw_r       <= 1'b1;
                        bus.from_sw_w       <= 1'b1;
                    end
                end
                StASetup: begin
                    state         <= StAStb;
                    cnt           <= StbLoad;
                    bus.from_sw_w <= 1'b0;
                end
                StAStb: begin
                    if (cnt == '0) begin
                        state         <= StAHold;
                        bus.from_sw_w <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                StAHold: begin
                    state          <= StARec;
                    cnt            <= RecLoad;
                    bus.from_sw_cs <= 1'b1;
                    bus.from_sw_r  <= 1'b1;
                    bus.from_sw_w  <= 1'b1;
                end
                StARec: begin
                    if (cnt == '0) begin
                        state                <= StDSetup;
                        bus.from_sw_cs       <= 1'b0;
                        bus.from_sw_address  <= 2'b00;
                        bus.from_sw_data_out <= we_q ? wdata_q : 16'h0000;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                StDSetup: begin
                    state <= StDStb;
                    cnt   <= StbLoad;
                    if (we_q) begin
                        bus.from_sw_w <= 1'b0;
                    end else begin
                        bus.from_sw_r <= 1'b0;
                    end
                end
                StDStb: begin
                    if (cnt == '0) begin
                        state         <= StDHold;
                        bus.from_sw_r <= 1'b1;
                        bus.from_sw_w <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                StDHold: begin
                    state          <= StDRec;
                    cnt            <= RecLoad;
                    bus.from_sw_cs <= 1'b1;
                    // hpi_io_intf registers both ways, so read data is only settled here.
                    if (!we_q) begin
                        bus.rdata <= bus.from_sw_data_in;
                    end
                end
                StDRec: begin
                    if (cnt == '0) begin
                        state <= StDone;
                        if (gnt) begin
                            bus.ack1 <= 1'b1;
                        end else begin
                            bus.ack0 <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                StDone: begin
                    state    <= StIdle;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hpi_access_arbiter.sv
// Self-checking bench: per-cycle comparison against a phase-arithmetic model of the
// HPI sequence, with a simple HPI device model behind the DUT.
module tb_hpi_access_arbiter;

    localparam int S     = 2;
    localparam int R     = 2;
    localparam int P     = 2 + S + R;
    localparam int ACK_K = 2 * P + 1;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    hpi_access_arbiter_if hif ();
    hpi_access_arbiter_if hif_f ();

    hpi_access_arbiter #(.STROBE_CYC(S), .REC_CYC(R)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (hif)
    );

    hpi_access_arbiter #(.STROBE_CYC(1), .REC_CYC(1)) dut_f (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (hif_f)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- HPI device model ----------------
    function automatic logic [15:0] mem_default(input logic [15:0] a);
        return (a == 16'h0500) ? 16'hBEEF : ~a;
    endfunction

    logic [15:0] hpi_addr;
    logic [15:0] hpi_mem [65536];
    bit          hpi_wr  [65536];

    always @(posedge Clk) begin
        if (!hif.from_sw_cs && !hif.from_sw_w) begin
            if (hif.from_sw_address == 2'b10) begin
                hpi_addr <= hif.from_sw_data_out;
            end else begin
                hpi_mem[hpi_addr] <= hif.from_sw_data_out;
                hpi_wr[hpi_addr]  <= 1'b1;
            end
        end
        if (!hif.from_sw_cs && !hif.from_sw_r && hif.from_sw_address == 2'b00) begin
            hif.from_sw_data_in <= hpi_wr[hpi_addr] ? hpi_mem[hpi_addr] : mem_default(hpi_addr);
        end
    end

    assign hif_f.from_sw_data_in = 16'h2468;

    // ---------------- reference model ----------------
    logic [15:0] ref_mem [65536];
    bit          ref_wr  [65536];
    int          m_k;       // cycles into current transaction, 0 = idle
    bit          m_g, m_last, m_we;
    logic [15:0] m_addr, m_wdata, m_rdata;

    function automatic logic [15:0] ref_read(input logic [15:0] a);
        return ref_wr[a] ? ref_mem[a] : mem_default(a);
    endfunction

    function automatic logic [39:0] act();
        return {hif.from_sw_cs, hif.from_sw_r, hif.from_sw_w, hif.busy, hif.ack0, hif.ack1,
                hif.from_sw_address, hif.from_sw_data_out, hif.rdata};
    endfunction

    task automatic exp_vec(output logic [39:0] e, output logic [39:0] m);
        logic cs = 1'b1, r = 1'b1, w = 1'b1, busy = 1'b0, a0 = 1'b0, a1 = 1'b0;
        logic [1:0]  adr = 2'b00;
        logic [15:0] dat = 16'h0;
        bit madr = 0, mdat = 0, mrd = 0;
        int ph, idx;
        if (m_k == 0) begin
            mrd = 1;
        end else if (m_k == ACK_K) begin
            busy = 1'b1; a0 = !m_g; a1 = m_g; mrd = 1;
        end else begin
            ph   = (m_k - 1) / P;
            idx  = (m_k - 1) % P;
            busy = 1'b1;
            if (idx <= S + 1) begin
                cs   = 1'b0;
                madr = 1;
                adr  = (ph == 0) ? 2'b10 : 2'b00;
                if (ph == 0) begin
                    mdat = 1; dat = m_addr;
                end else if (m_we) begin
                    mdat = 1; dat = m_wdata;
                end
                if (idx >= 1 && idx <= S) begin
                    if (ph == 0 || m_we) w = 1'b0;
                    else r = 1'b0;
                end
            end
        end
        e = {cs, r, w, busy, a0, a1, adr, dat, m_rdata};
        m = {6'h3f, {2{madr}}, {16{mdat}}, {16{mrd}}};
    endtask

    task automatic check_vec(input string name, input logic [39:0] a, input logic [39:0] e,
                             input logic [39:0] m);
        checks++;
        if ((a & m) !== (e & m)) begin
            errors++;
            $display("FAIL %s k=%0d t=%0t actual=%h required=%h mask=%h",
                     name, m_k, $time, a, e, m);
        end
    endtask

    task automatic chk(input string name, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, a, e);
        end
    endtask

    // Advance the model across one edge using the inputs in place now, then compare.
    task automatic tick();
        logic [39:0] e, m;
        if (m_k == 0) begin
            if (hif.req0 && (!hif.req1 || m_last)) begin
                m_g = 0; m_we = hif.we0; m_addr = hif.addr0; m_wdata = hif.wdata0;
                m_last = 0; m_k = 1;
            end else if (hif.req1) begin
                m_g = 1; m_we = hif.we1; m_addr = hif.addr1; m_wdata = hif.wdata1;
                m_last = 1; m_k = 1;
            end
        end else if (m_k == ACK_K) begin
            m_k = 0;
        end else begin
            m_k++;
        end
        if (m_k == ACK_K) begin
            if (m_we) begin
                ref_mem[m_addr] = m_wdata;
                ref_wr[m_addr]  = 1'b1;
            end else begin
                m_rdata = ref_read(m_addr);
            end
        end
        @(posedge Clk);
        #1;
        exp_vec(e, m);
        check_vec("cyc", act(), e, m);
    endtask

    task automatic do_reset(input string name);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        m_k = 0; m_last = 1; m_rdata = 16'h0;
        check_vec(name, act(), {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0},
                  {40{1'b1}});
        Reset = 1'b0;
    endtask

    task automatic set_req(input bit p, input bit rq, input bit we, input logic [15:0] a,
                           input logic [15:0] d);
        if (p) begin
            hif.req1 = rq; hif.we1 = we; hif.addr1 = a; hif.wdata1 = d;
        end else begin
            hif.req0 = rq; hif.we0 = we; hif.addr0 = a; hif.wdata0 = d;
        end
    endtask

    // One isolated transaction on the default DUT; checks ack latency and rdata.
    task automatic run_one(input bit p, input bit we, input logic [15:0] a, input logic [15:0] d,
                           input logic [15:0] exp_rd);
        int n = 0;
        bit got = 0;
        set_req(p, 1'b1, we, a, d);
        while (!got && n < 40) begin
            tick();
            n++;
            if (p ? hif.ack1 : hif.ack0) got = 1;
        end
        set_req(p, 1'b0, we, a, d);
        chk("ack_cyc", got ? n : -1, 13);
        chk("rdata", int'(hif.rdata), int'(exp_rd));
        tick();
    endtask

    task automatic fast_txn(input bit p, input bit we, input logic [15:0] a);
        int n = 0, wl = 0, rl = 0;
        bit got = 0;
        if (p) begin
            hif_f.req1 = 1'b1; hif_f.we1 = we; hif_f.addr1 = a;
        end else begin
            hif_f.req0 = 1'b1; hif_f.we0 = we; hif_f.addr0 = a;
        end
        while (!got && n < 30) begin
            @(posedge Clk);
            #1;
            n++;
            if (!hif_f.from_sw_w) wl++;
            if (!hif_f.from_sw_r) rl++;
            if (p ? hif_f.ack1 : hif_f.ack0) got = 1;
        end
        hif_f.req0 = 1'b0;
        hif_f.req1 = 1'b0;
        chk("fast_ack_cyc", got ? n : -1, 9);
        chk("fast_w_low", wl, we ? 2 : 1);
        chk("fast_r_low", rl, we ? 0 : 1);
        if (!we) chk("fast_rdata", int'(hif_f.rdata), 16'h2468);
        @(posedge Clk);
        #1;
    endtask

    typedef struct {
        bit          port;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int order [4];
        int nack;
        int n;

        tbl[0] = '{port: 0, we: 1, addr: 16'h1234, wdata: 16'hA5A5, exp_rdata: 16'h0000};
        tbl[1] = '{port: 1, we: 0, addr: 16'h0500, wdata: 16'h0000, exp_rdata: 16'hBEEF};
        tbl[2] = '{port: 0, we: 0, addr: 16'h1234, wdata: 16'h0000, exp_rdata: 16'hA5A5};
        tbl[3] = '{port: 1, we: 1, addr: 16'h0500, wdata: 16'h0F0F, exp_rdata: 16'hA5A5};
        tbl[4] = '{port: 0, we: 0, addr: 16'h0500, wdata: 16'h0000, exp_rdata: 16'h0F0F};
        tbl[5] = '{port: 1, we: 0, addr: 16'h7777, wdata: 16'h0000, exp_rdata: 16'h8888};

        set_req(0, 0, 0, 16'h0, 16'h0);
        set_req(1, 0, 0, 16'h0, 16'h0);
        hif_f.req0 = 0; hif_f.req1 = 0; hif_f.we0 = 0; hif_f.we1 = 0;
        hif_f.addr0 = 0; hif_f.addr1 = 0; hif_f.wdata0 = 16'h1111; hif_f.wdata1 = 16'h2222;
        m_addr = 0; m_wdata = 0; m_we = 0; m_g = 0;

        do_reset("reset");
        tick();

        for (int i = 0; i < 6; i++) begin
            run_one(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata);
        end

        // Simultaneous requests straight after reset, held for four transactions.
        do_reset("reset2");
        set_req(0, 1, 1, 16'h2000, 16'h1357);
        set_req(1, 1, 0, 16'h2000, 16'h0000);
        nack = 0;
        n = 0;
        while (nack < 4 && n < 200) begin
            tick();
            n++;
            if (hif.ack0 || hif.ack1) begin
                order[nack] = hif.ack1 ? 1 : 0;
                nack++;
            end
        end
        set_req(0, 0, 0, 16'h0, 16'h0);
        set_req(1, 0, 0, 16'h0, 16'h0);
        chk("rr_count", nack, 4);
        for (int i = 0; i < 4; i++) begin
            chk("rr_order", (i < nack) ? order[i] : -1, i % 2);
        end
        tick();
        tick();

        // Reset while the address strobe is low.
        set_req(0, 1, 1, 16'h3000, 16'h1111);
        tick();
        tick();
        chk("abort_in_stb", int'(hif.from_sw_w), 0);
        set_req(0, 0, 0, 16'h0, 16'h0);
        do_reset("abort_reset");
        for (int i = 0; i < 4; i++) tick();
        run_one(1, 0, 16'h3000, 16'h0, 16'hCFFF);

        // Random traffic from both ports.
        for (int c = 0; c < 1500; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!(p ? hif.req1 : hif.req0) && ($urandom % 3 == 0)) begin
                    set_req(p[0], 1, 1'($urandom), {12'h0A0, 4'($urandom)}, 16'($urandom));
                end
            end
            tick();
            if (m_k == ACK_K) begin
                if ($urandom % 2 == 1) begin
                    set_req(m_g, 1, 1'($urandom), {12'h0A0, 4'($urandom)}, 16'($urandom));
                end else begin
                    set_req(m_g, 0, 0, 16'h0, 16'h0);
                end
            end
        end
        set_req(0, 0, 0, 16'h0, 16'h0);
        set_req(1, 0, 0, 16'h0, 16'h0);
        for (int i = 0; i < ACK_K + 2; i++) tick();

        // Minimum timing instance.
        fast_txn(0, 1, 16'h0042);
        fast_txn(1, 0, 16'h0042);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hpi_access_arbiter.md
# hpi_access_arbiter

Hardware sequencer and two-port arbiter for the CY7C67200 HPI path. It accepts whole-word memory read/write requests from two requesters, grants them round-robin, and expands each into the two-access HPI sequence: write the memory address to the HPI ADDRESS port, then read or write the HPI DATA port. It drives the `from_sw_*` side of `hpi_io_intf` in place of software-driven bit-banging.

## Interface
Parameters:
- `STROBE_CYC`, default 2: cycles RD/WR strobe is held low per access; legal range ≥1.
- `REC_CYC`, default 2: recovery cycles with CS high after each access; legal range ≥1.

Ports:
- `Clk`  in  1  single clock; all state changes on its rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `req0`, `req1`  in  1  transaction request, one per port; held high with fields stable until ack.
- `we0`, `we1`  in  1  1 = write, 0 = read.
- `addr0`, `addr1`  in  16  CY7C67200 memory address.
- `wdata0`, `wdata1`  in  16  write data.
- `ack0`, `ack1`  out  1  one-cycle completion pulse.
- `rdata`  out  16  read result; shared by both ports.
- `busy`  out  1  high in every state except IDLE.
- `from_sw_address`  out  2  HPI port select: ADDRESS = 2'b10, DATA = 2'b00.
- `from_sw_data_out`  out  16  data to `hpi_io_intf`.
- `from_sw_data_in`  in  16  registered HPI read data from `hpi_io_intf`.
- `from_sw_r`, `from_sw_w`, `from_sw_cs`  out  1  active-low strobes and chip select.

## Operation
- Reset values: `from_sw_cs`/`from_sw_r`/`from_sw_w` = 1, `from_sw_address` = 2'b00, `from_sw_data_out` = 0, `rdata` = 0, `ack0`/`ack1` = 0, `busy` = 0, state IDLE, last-grant = port 1 (so port 0 wins the first tie).
- States: IDLE → A_SETUP → A_STB → A_HOLD → A_REC → D_SETUP → D_STB → D_HOLD → D_REC → DONE → IDLE.
- IDLE: sample `req0`/`req1`. If exactly one is high, grant it. If both are high, grant the port not granted last. Latch `we`, `addr` and `wdata` of the granted port; update last-grant.
- A_SETUP (1 cycle): cs = 0, address = 2'b10, data_out = latched addr; r = w = 1.
- A_STB (`STROBE_CYC` cycles): w = 0; all other outputs unchanged.
- A_HOLD (1 cycle): w = 1; cs, address and data_out are held.
- A_REC (`REC_CYC` cycles): cs = 1, all strobes = 1.
- D_SETUP (1 cycle): cs = 0, address = 2'b00, data_out = latched wdata for writes.
- D_STB (`STROBE_CYC` cycles): w = 0 for writes, r = 0 for reads.
- D_HOLD (1 cycle): strobes = 1. For reads, `rdata` <= `from_sw_data_in` at the end of this cycle. This accounts for the input and output registers in `hpi_io_intf`.
- D_REC (`REC_CYC` cycles): cs = 1.
- DONE (1 cycle): `ack` of the granted port = 1; then return to IDLE.
- `rdata` is valid from the ack cycle and held until the next read captures. Writes never change `rdata`.
- `from_sw_r` and `from_sw_w` are never both 0. `from_sw_w` is 0 only during A_STB or write D_STB; this keeps the OTG_DATA tristate released at all other times.
- A requester that keeps `req` high after its ack is treated as issuing a new request when IDLE samples it, and is subject to round-robin.
- Requests arriving while busy are ignored until IDLE. No queuing.

## Timing
- Phase length: P = 2 + `STROBE_CYC` + `REC_CYC` cycles (6 at defaults).
- Request sampled in IDLE at cycle 0; A_SETUP starts at cycle 1; D_SETUP at cycle 1+P; ack at cycle 1+2P (13 at defaults).
- Next grant is sampled at cycle 2+2P, so back-to-back throughput is one transaction per 2+2P cycles.
- Reset asserted in any state, including mid-strobe: at the next edge every output returns to its reset value and the state goes to IDLE. No ack is issued for the aborted transaction, and last-grant returns to port 1.
- Counter width: ≥ clog2(max(`STROBE_CYC`, `REC_CYC`)) + 1. The counter reloads on each state entry.

## Test plan
- Port-0 write, addr 16'h1234, wdata 16'hA5A5, defaults. Required: addr phase at cycles 1–6 with address = 2'b10, data = 16'h1234, w low for cycles 2–3; data phase at cycles 7–12 with address = 2'b00, data = 16'hA5A5, w low for cycles 8–9; ack0 at cycle 13; r stays 1 throughout.
- Port-1 read, addr 16'h0500; HPI model returns 16'hBEEF. Required: r low for cycles 8–9, w high throughout the data phase; `rdata` = 16'hBEEF with ack1 at cycle 13.
- `req0` and `req1` rise in the same cycle after reset. Required: port 0 is served first; port 1 is granted at the next IDLE; exactly one ack per port.
- Both ports hold `req` high continuously for 4 transactions. Required: grant order 0,1,0,1; ack0/ack1 never high together.
- `Reset` asserted during A_STB of a write. Required: cs, r and w all 1 at the next edge; busy = 0; no ack; a new port-1 request completes normally afterward.
- `STROBE_CYC` = 1, `REC_CYC` = 1. Required: ack at cycle 9; strobes low exactly 1 cycle per access.
